// File: rtl/instr_loader.sv
// instr_loader: streams instruction words into instruction memory, then releases the CPU from reset
// Optional feature macro: LOADER_CHECKSUM_EN adds the checksum output.
// Ports:
//   CLK, resetl                 clock, asynchronous active-low reset
//   start, load_base            begin a load at byte address load_base (accepted in IDLE/RUN)
//   in_valid/in_data/in_last    word stream in; in_ready high only in LOAD
//   imem_we/imem_addr/imem_wdata one-cycle write per accepted word, one cycle after acceptance
//   cpu_resetl, cpu_startpc     CPU reset (high only in RUN) and latched start PC
//   busy, err_overflow          high in LOAD/HOLD; sticky truncation flag for the last load
//   checksum                    mod-2^32 sum of the words of the current load (LOADER_CHECKSUM_EN)
module instr_loader #(
    parameter int MAX_WORDS   = 256,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic [63:0] load_base,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        imem_we,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_resetl,
    output logic [63:0] cpu_startpc,
    output logic        busy,
`ifdef LOADER_CHECKSUM_EN
    output logic        err_overflow,
    output logic [31:0] checksum
`else
    output logic        err_overflow
`endif
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [63:0]   base_q, base_d, addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d, err_q, err_d;
    logic          accept, go, full;
    always_comb begin
        accept  = state_q == LOAD && in_valid;
        go      = start && (state_q == IDLE || state_q == RUN);
        full    = count_q == CW'(MAX_WORDS - 1);
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        base_d  = base_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = err_q;
        if (go) begin
            state_d = LOAD;
            base_d  = load_base;
            count_d = '0;
            err_d   = 1'b0;
        end
        if (accept) begin
            we_d    = 1'b1;
            addr_d  = base_q + (64'(count_q) << 2);
            wdata_d = in_data;
            count_d = count_q + 1'b1;
            if (in_last || full) begin
                state_d = HOLD;
                hold_d  = HW'(HOLD_CYCLES - 1);
                err_d   = !in_last;
            end
        end
        if (state_q == HOLD) begin
            state_d = hold_q == '0 ? RUN : HOLD;
            hold_d  = hold_q == '0 ? hold_q : hold_q - 1'b1;
        end
    end
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            count_q <= '0;
            hold_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end
    assign in_ready     = state_q == LOAD;
    assign busy         = state_q == LOAD || state_q == HOLD;
    assign cpu_resetl   = state_q == RUN;
    assign cpu_startpc  = base_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign err_overflow = err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    always_comb sum_d = go ? '0 : accept ? sum_q + in_data : sum_q;
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) sum_q <= '0;
        else sum_q <= sum_d;
    end
    assign checksum = sum_q;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized and directed scoreboard bench for instr_loader
module tb_instr_loader;
    localparam int MAXW = 4;
    localparam int HOLD = 4;
    logic        CLK = 1'b0, resetl = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [63:0] load_base = '0;
    logic [31:0] in_data = '0;
    logic        in_ready, imem_we, cpu_resetl, busy, err_overflow;
    logic [63:0] imem_addr, cpu_startpc;
    logic [31:0] imem_wdata, checksum;
    instr_loader #(.MAX_WORDS(MAXW), .HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .resetl(resetl), .start(start), .load_base(load_base),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_resetl(cpu_resetl), .cpu_startpc(cpu_startpc), .busy(busy),
`ifdef LOADER_CHECKSUM_EN
        .err_overflow(err_overflow), .checksum(checksum)
`else
        .err_overflow(err_overflow)
`endif
    );
`ifndef LOADER_CHECKSUM_EN
    assign checksum = '0;
`endif
    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0, cyc_n = 0, m_end = 0;
    logic [95:0] exp_q[$];
    logic [95:0] mon_e;
    // reference model: a load is just a base, a word count and a running sum
    logic        m_loading = 1'b0, m_err = 1'b0;
    logic [63:0] m_base = '0;
    int          m_count = 0;
    logic [31:0] m_sum = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got write at %h expected none", imem_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("imem_addr", imem_addr, mon_e[95:32]);
                chk("imem_wdata", {32'b0, imem_wdata}, {32'b0, mon_e[31:0]});
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
        cyc_n++;
    endtask

    task automatic do_start(input logic [63:0] b);
        start = 1'b1;
        load_base = b;
        m_loading = 1'b1;
        m_base = b;
        m_count = 0;
        m_err = 1'b0;
        m_sum = '0;
        cyc();
        start = 1'b0;
        load_base = {$urandom, $urandom};
        chk("cpu_resetl_in_load", {63'b0, cpu_resetl}, 64'd0);
        chk("busy_in_load", {63'b0, busy}, 64'd1);
    endtask

    task automatic stray_start(input logic [63:0] b);
        start = 1'b1;
        load_base = b;
        cyc();
        start = 1'b0;
    endtask

    task automatic offer(input logic [31:0] d, input logic l, input logic v);
        in_valid = v;
        in_data = d;
        in_last = l;
        chk("in_ready", {63'b0, in_ready}, {63'b0, m_loading});
        if (v && m_loading) begin
            exp_q.push_back({m_base + 64'(m_count) * 64'd4, d});
            m_sum += d;
            m_count++;
            if (l || m_count == MAXW) begin
                m_loading = 1'b0;
                m_err = !l;
                m_end = cyc_n;
            end
        end
        cyc();
        in_valid = 1'b0;
        in_data = $urandom;
        in_last = $urandom;
    endtask

    task automatic wait_run();
        int g = 0;
        while (!cpu_resetl && g < 50) begin
            g++;
            cyc();
        end
        chk("hold_length", 64'(cyc_n - m_end), 64'(HOLD + 1));
        chk("cpu_resetl_run", {63'b0, cpu_resetl}, 64'd1);
        chk("cpu_startpc", cpu_startpc, m_base);
        chk("err_overflow", {63'b0, err_overflow}, {63'b0, m_err});
        chk("busy_run", {63'b0, busy}, 64'd0);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("checksum", {32'b0, checksum}, {32'b0, m_sum});
`endif
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_in_ready"}, {63'b0, in_ready}, 64'd0);
        chk({nm, "_imem_we"}, {63'b0, imem_we}, 64'd0);
        chk({nm, "_imem_addr"}, imem_addr, 64'd0);
        chk({nm, "_imem_wdata"}, {32'b0, imem_wdata}, 64'd0);
        chk({nm, "_cpu_resetl"}, {63'b0, cpu_resetl}, 64'd0);
        chk({nm, "_cpu_startpc"}, cpu_startpc, 64'd0);
        chk({nm, "_busy"}, {63'b0, busy}, 64'd0);
        chk({nm, "_err_overflow"}, {63'b0, err_overflow}, 64'd0);
        chk({nm, "_checksum"}, {32'b0, checksum}, 64'd0);
    endtask

    initial begin
        #2 resetl = 1'b0;
        #1 chk_zero("reset");
        cyc();
        cyc();
        resetl = 1'b1;
        cyc();
        chk("idle_after_reset", {62'b0, in_ready, cpu_resetl}, 64'd0);
        // basic three-word load from address 0
        do_start(64'h0);
        offer(32'h8B020020, 1'b0, 1'b1);
        offer(32'hCB010000, 1'b0, 1'b1);
        offer(32'h17FFFFFF, 1'b1, 1'b1);
        wait_run();
        // valid toggling, a start ignored mid-load, and junk in_last on idle cycles
        do_start(64'h100);
        offer(32'h11111111, 1'b0, 1'b1);
        offer(32'hDEADBEEF, 1'b1, 1'b0);
        stray_start(64'h999);
        offer(32'h22222222, 1'b1, 1'b1);
        offer(32'hDEADBEEF, 1'b1, 1'b0);
        wait_run();
        // truncation at MAX_WORDS: six words, no last
        do_start(64'h1000);
        for (int i = 0; i < 6; i++) offer($urandom, 1'b0, 1'b1);
        wait_run();
        // restart from RUN at 0x40
        do_start(64'h40);
        offer(32'hA5A5A5A5, 1'b1, 1'b1);
        wait_run();
        // wrap past the top of the 64-bit address space is not an error
        do_start(64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 3; i++) offer($urandom, 1'b0, 1'b1);
        offer($urandom, 1'b1, 1'b1);
        wait_run();
        // checksum wraps modulo 2^32
        do_start(64'h300);
        offer(32'hFFFFFFFF, 1'b0, 1'b1);
        offer(32'h00000002, 1'b1, 1'b1);
        wait_run();
`ifdef LOADER_CHECKSUM_EN
        chk("checksum_wrap", {32'b0, checksum}, 64'd1);
`endif
        // randomized loads
        for (int n = 0; n < 12; n++) begin
            int len, tries;
            len = $urandom_range(1, 6);
            tries = 0;
            do_start(n % 4 == 3 ? 64'hFFFF_FFFF_FFFF_FFF4 : {$urandom, $urandom} & ~64'h3);
            while (m_loading && tries < 40) begin
                tries++;
                offer($urandom, m_count == len - 1, $urandom_range(0, 2) != 0);
            end
            if (m_loading) chk("load_stuck", 64'd1, 64'd0);
            wait_run();
        end
        // reset in the middle of a load: two words written, a third offered as reset hits
        do_start(64'h200);
        offer(32'h01010101, 1'b0, 1'b1);
        offer(32'h02020202, 1'b0, 1'b1);
        offer(32'h0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data = 32'h03030303;
        resetl = 1'b0;
        m_loading = 1'b0;
        #1 chk_zero("midload_reset");
        cyc();
        cyc();
        resetl = 1'b1;
        for (int i = 0; i < 4; i++) offer($urandom, 1'b0, 1'b1);
        chk("idle_cpu_resetl", {63'b0, cpu_resetl}, 64'd0);
        chk("idle_busy", {63'b0, busy}, 64'd0);
        chk("no_writes_after_reset", 64'(exp_q.size()), 64'd0);
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: maximum instruction words per load.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: number of cycles cpu_resetl stays low after a load completes.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port resetl, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-006 SHALL have port load_base, input, 64 bits: byte address of the first word; sampled when start is accepted.
REQ-007 SHALL have port in_valid, input, 1 bit: an instruction word is offered.
REQ-008 SHALL have port in_data, input, 32 bits: the offered instruction word.
REQ-009 SHALL have port in_last, input, 1 bit: the offered word is the final word of the load.
REQ-010 SHALL have port in_ready, output, 1 bit: the loader accepts the offered word.
REQ-011 SHALL have port imem_we, output, 1 bit: write strobe to instruction memory.
REQ-012 SHALL have port imem_addr, output, 64 bits: write byte address to instruction memory.
REQ-013 SHALL have port imem_wdata, output, 32 bits: write data to instruction memory.
REQ-014 SHALL have port cpu_resetl, output, 1 bit: active-low reset to the processor.
REQ-015 SHALL have port cpu_startpc, output, 64 bits: start PC presented to the processor.
REQ-016 SHALL have port busy, output, 1 bit: high in LOAD and HOLD.
REQ-017 SHALL have port err_overflow, output, 1 bit: sticky flag; the last load was truncated at MAX_WORDS.

Function
REQ-018 SHALL implement an FSM with states IDLE, LOAD, HOLD and RUN.
REQ-019 IDLE: start=1 SHALL latch load_base into base and cpu_startpc, clear the word count and err_overflow, and go to LOAD.
REQ-020 LOAD: in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-021 A word SHALL be accepted only when in_valid and in_ready are both high; in_data/in_last SHALL be ignored otherwise.
REQ-022 Accepting a word SHALL cause, on the next cycle, imem_we=1 for exactly one cycle with imem_addr = base + 4*count and imem_wdata = the accepted word; count then increments. Latency from acceptance to write is 1 cycle.
REQ-023 Address arithmetic SHALL be 64-bit modulo 2^64; a wrap past 0xFFFF_FFFF_FFFF_FFFC SHALL NOT be flagged.
REQ-024 Accepting a word with in_last=1 SHALL move LOAD to HOLD.
REQ-025 Accepting word number MAX_WORDS (count = MAX_WORDS-1) with in_last=0 SHALL write that word, set err_overflow, and move to HOLD; further words SHALL NOT be accepted.
REQ-026 HOLD SHALL last exactly HOLD_CYCLES cycles and then go to RUN; cpu_resetl SHALL be 0 in IDLE, LOAD and HOLD.
REQ-027 RUN: cpu_resetl SHALL be 1 starting the first cycle of RUN and cpu_startpc SHALL hold the latched base.
REQ-028 start in RUN SHALL act as in IDLE (relatch, go to LOAD), and cpu_resetl SHALL drop to 0 in the next cycle.
REQ-029 start in LOAD or HOLD SHALL be ignored.
REQ-030 A start and an accepted word in the same cycle SHALL be impossible by construction, since in_ready=0 outside LOAD.
REQ-031 A zero-word load SHALL NOT exist: the first accepted word is always written even when in_last=1.

Reset
REQ-032 resetl=0 SHALL immediately force: state IDLE, count 0, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_resetl 0, cpu_startpc 0, busy 0, err_overflow 0 (and checksum 0 when LOADER_CHECKSUM_EN is defined).
REQ-033 Reset asserted mid-LOAD SHALL abandon the load; no further imem_we pulse SHALL occur, including for a word accepted in the same cycle.
REQ-034 After resetl deasserts, the loader SHALL remain in IDLE until start.

Configuration
REQ-035 With macro LOADER_CHECKSUM_EN defined, the block SHALL add output checksum (32 bits), the modulo-2^32 sum of all words written in the current load; it is cleared on start and stable from HOLD onward.
REQ-036 Without LOADER_CHECKSUM_EN, the checksum port and its adder SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Reset, start with load_base=0, 3 words 0x8B020020, 0xCB010000, 0x17FFFFFF (last on word 3) -> writes at addresses 0x0, 0x4, 0x8; 4 HOLD cycles; cpu_resetl=1 and cpu_startpc=0.
REQ-038 in_valid toggling 1,0,1,0 with load_base=0x100 -> writes only on accepted words, at 0x100, 0x104; imem_we is never high 2 cycles per word.
REQ-039 MAX_WORDS=4, six words with no last -> 4 writes (last address base+0xC), err_overflow=1, in_ready=0 after the 4th word.
REQ-040 start during RUN with load_base=0x40 -> cpu_resetl=0 the next cycle; new load begins at 0x40.
REQ-041 resetl pulsed low after 2 of 5 words -> all outputs reset immediately; no further writes; IDLE.
REQ-042 With LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001.
